// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one word read per cycle to instruction memory
// while space allows, buffers returned words with their PC, and presents them to
// decode over valid/ready with an illegal-opcode qualifier on the head entry.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_rdata_i,
    input  logic                       flush_i,
    input  logic [31:0]                flush_pc_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [31:0]                instr_o,
    output logic [31:0]                pc_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_pc    [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_inflight;
    logic          r_drop;

    logic          w_req;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_occ;
    logic [DEPTH-1:0] w_we;

    // Opcodes decode knows how to handle; everything else is flagged.
    function automatic logic f_legal(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0010011,
            7'b0010111, 7'b0110111, 7'b1100111, 7'b1101111: f_legal = 1'b1;
            default:                                         f_legal = 1'b0;
        endcase
    endfunction

    // An in-flight request reserves a slot, so a response can never overflow.
    assign w_occ       = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_req       = reset && !flush_i && (w_occ < DEPTH_W);
    assign w_push      = r_inflight && !r_drop && !flush_i;
    assign w_pop       = valid_o && ready_i && !flush_i;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;
    assign valid_o     = (r_count != '0);
    assign count_o     = r_count;
    assign instr_o     = r_mem_instr[r_rptr];
    assign pc_o        = r_mem_pc[r_rptr];
    assign illegal_o   = valid_o && !f_legal(instr_o[6:0]);

    // Per-entry write enables decoded from the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = w_push && (r_wptr == PW'(gi));
        end
    endgenerate

    // Queue storage; cleared on reset so head outputs read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) begin
                    r_mem_instr[i] <= imem_rdata_i;
                    r_mem_pc[i]    <= r_req_pc;
                end
            end
        end
    end

    // Fetch PC, request tracking, pointers and occupancy; flush overrides all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (flush_i) begin
            r_fetch_pc <= {flush_pc_i[31:2], 2'b00};
            r_inflight <= 1'b0;
            r_drop     <= r_inflight;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_req) begin
                r_req_pc   <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_inflight <= w_req;
            r_drop     <= 1'b0;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule
